// File: rtl/acc_seq_pkg.sv
// rtl/acc_seq_pkg.sv - shared ALU control encodings, FSM state codes and queue entry type
package acc_seq_pkg;

  localparam logic [4:0] CTRL_ADD    = 5'b01001;
  localparam logic [4:0] CTRL_PASS_B = 5'b11010;
  localparam logic [4:0] CTRL_ZERO   = 5'b10011;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_RESULT = 2'd2
  } state_e;

  typedef struct packed {
    logic [4:0] ctrl;
    logic       cin_n;
    logic [3:0] b;
    logic       last;
  } cmd_t;

endpackage

// File: rtl/alu_4bit.sv
// rtl/alu_4bit.sv - 74181-style 4-bit ALU, active-high data, active-low carry in/out
module alu_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       cin_re,
  output logic       cout_re,
  output logic [3:0] y
);

  logic [3:0] p;
  logic [3:0] q;
  logic [3:0] lg;
  logic [4:0] sum;

  // Arithmetic mode is expressed as p + q + carry; "minus 1" terms use q = 4'hF
  always_comb begin
    p  = a;
    q  = 4'h0;
    lg = 4'h0;
    case (s)
      4'h0: begin p = a;        q = 4'h0;    lg = ~a;       end
      4'h1: begin p = a | b;    q = 4'h0;    lg = ~(a | b); end
      4'h2: begin p = a | ~b;   q = 4'h0;    lg = ~a & b;   end
      4'h3: begin p = 4'h0;     q = 4'hF;    lg = 4'h0;     end
      4'h4: begin p = a;        q = a & ~b;  lg = ~(a & b); end
      4'h5: begin p = a | b;    q = a & ~b;  lg = ~b;       end
      4'h6: begin p = a;        q = ~b;      lg = a ^ b;    end
      4'h7: begin p = a & ~b;   q = 4'hF;    lg = a & ~b;   end
      4'h8: begin p = a;        q = a & b;   lg = ~a | b;   end
      4'h9: begin p = a;        q = b;       lg = ~(a ^ b); end
      4'hA: begin p = a | ~b;   q = a & b;   lg = b;        end
      4'hB: begin p = a & b;    q = 4'hF;    lg = a & b;    end
      4'hC: begin p = a;        q = a;       lg = 4'hF;     end
      4'hD: begin p = a | b;    q = a;       lg = a | ~b;   end
      4'hE: begin p = a | ~b;   q = a;       lg = a | b;    end
      default: begin p = a;     q = 4'hF;    lg = a;        end
    endcase
    sum     = {1'b0, p} + {1'b0, q} + {4'b0000, ~cin_re};
    y       = m ? lg : sum[3:0];
    cout_re = m ? 1'b1 : ~sum[4];
  end

endmodule

// File: rtl/acc_seq.sv
// rtl/acc_seq.sv - queued accumulator sequencer around alu_4bit with result handshake
module acc_seq
  import acc_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [4:0] cmd_ctrl,
  input  logic       cmd_cin_n,
  input  logic [3:0] cmd_b,
  input  logic       cmd_last,
  input  logic       clr_on_ovf,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic       res_ovf,
  output logic [3:0] acc,
  output logic       busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  state_e        state_q, state_d;
  logic [3:0]    acc_q, acc_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  cmd_t          mem_q [FIFO_DEPTH];
  cmd_t          mem_d [FIFO_DEPTH];

  cmd_t       head;
  cmd_t       cmd_in;
  logic       push;
  logic       exec;
  logic       ovf_evt;
  logic       alu_cout_n;
  logic [3:0] alu_y;

  assign cmd_in    = '{ctrl: cmd_ctrl, cin_n: cmd_cin_n, b: cmd_b, last: cmd_last};
  assign head      = mem_q[rd_ptr_q];
  assign cmd_ready = (count_q != CW'(FIFO_DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign exec      = (state_q == ST_EXEC) && (count_q != '0);
  assign ovf_evt   = exec && (head.ctrl == CTRL_ADD) && !alu_cout_n;

  alu_4bit u_alu (
    .a       (acc_q),
    .b       (head.b),
    .s       (head.ctrl[3:0]),
    .m       (head.ctrl[4]),
    .cin_re  (head.cin_n),
    .cout_re (alu_cout_n),
    .y       (alu_y)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = cmd_in;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (exec) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      acc_d    = (ovf_evt && clr_on_ovf) ? 4'h0 : alu_y;
      if (ovf_evt) ovf_d = 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(exec);
    // Decisions use the post-edge occupancy so a same-cycle push is never stranded in IDLE
    case (state_q)
      ST_IDLE: begin
        if (count_d != '0) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (exec && head.last)   state_d = ST_RESULT;
        else if (count_d == '0)  state_d = ST_IDLE;
      end
      ST_RESULT: begin
        if (res_ready) begin
          ovf_d   = 1'b0;
          state_d = (count_d != '0) ? ST_EXEC : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      acc_q    <= 4'h0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign res_valid = (state_q == ST_RESULT);
  assign res_data  = res_valid ? acc_q : 4'h0;
  assign res_ovf   = res_valid && ovf_q;
  assign acc       = acc_q;
  assign busy      = (count_q != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_acc_seq.sv
// tb/tb_acc_seq.sv - directed and randomized checks of acc_seq against a behavioural model
module tb_acc_seq;
  import acc_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [4:0] cmd_ctrl = 5'b0;
  logic       cmd_cin_n = 1'b1;
  logic [3:0] cmd_b = 4'h0;
  logic       cmd_last = 1'b0;
  logic       clr_on_ovf = 1'b0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [3:0] res_data;
  logic       res_ovf;
  logic [3:0] acc;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int m_acc = 0;
  bit m_ovf = 1'b0;

  acc_seq #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ctrl(cmd_ctrl), .cmd_cin_n(cmd_cin_n), .cmd_b(cmd_b), .cmd_last(cmd_last),
    .clr_on_ovf(clr_on_ovf), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_ovf(res_ovf), .acc(acc), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Accumulator semantics written directly from the operation definitions
  task automatic model_step(input logic [4:0] c, input bit cn, input int b);
    int sum;
    if (c == CTRL_ADD) begin
      sum = m_acc + b + (cn ? 0 : 1);
      if (sum > 15) begin
        m_ovf = 1'b1;
        m_acc = clr_on_ovf ? 0 : sum - 16;
      end else begin
        m_acc = sum;
      end
    end else if (c == CTRL_PASS_B) begin
      m_acc = b;
    end else begin
      m_acc = 0;
    end
  endtask

  task automatic push(input logic [4:0] c, input bit cn, input logic [3:0] b, input bit last);
    int n = 0;
    cmd_valid = 1'b1; cmd_ctrl = c; cmd_cin_n = cn; cmd_b = b; cmd_last = last;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("push_timeout", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic send(input logic [4:0] c, input bit cn, input logic [3:0] b, input bit last);
    model_step(c, cn, b);
    push(c, cn, b, last);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic get_result(input int exp_data, input bit exp_ovf, input int hold);
    wait_valid();
    chk("res_valid", res_valid, 1);
    chk("res_data", res_data, exp_data);
    chk("res_ovf", res_ovf, exp_ovf);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_data", res_data, exp_data);
      chk("hold_ovf", res_ovf, exp_ovf);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    m_ovf = 1'b0;
  endtask

  initial begin
    int n;
    int sel;
    logic [4:0] c;

    repeat (2) @(negedge clk);
    chk("rst_acc", acc, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_ovf", res_ovf, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic two-command result
    send(CTRL_PASS_B, 1'b1, 4'd3, 1'b0);
    send(CTRL_ADD, 1'b1, 4'd5, 1'b1);
    get_result(8, 1'b0, 1);
    chk("basic_busy_after", busy, 0);
    chk("basic_valid_after", res_valid, 0);

    // Overflow with and without clear
    clr_on_ovf = 1'b1;
    send(CTRL_PASS_B, 1'b1, 4'd12, 1'b0);
    send(CTRL_ADD, 1'b1, 4'd7, 1'b1);
    get_result(0, 1'b1, 0);
    clr_on_ovf = 1'b0;
    send(CTRL_PASS_B, 1'b1, 4'd12, 1'b0);
    send(CTRL_ADD, 1'b1, 4'd7, 1'b1);
    get_result(3, 1'b1, 0);

    // Fill the queue while a result is held
    send(CTRL_PASS_B, 1'b1, 4'd2, 1'b1);
    wait_valid();
    chk("full_res_valid", res_valid, 1);
    send(CTRL_ADD, 1'b1, 4'd1, 1'b0);
    send(CTRL_ADD, 1'b1, 4'd2, 1'b0);
    send(CTRL_ADD, 1'b1, 4'd3, 1'b0);
    chk("full_ready_at3", cmd_ready, 1);
    send(CTRL_ADD, 1'b1, 4'd4, 1'b0);
    chk("full_ready_at4", cmd_ready, 0);
    chk("full_res_data", res_data, 2);
    cmd_valid = 1'b1; cmd_ctrl = CTRL_ADD; cmd_cin_n = 1'b1; cmd_b = 4'd1; cmd_last = 1'b1;
    model_step(CTRL_ADD, 1'b1, 1);
    @(negedge clk);
    chk("full_ready_held", cmd_ready, 0);
    chk("full_acc_held", acc, 2);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    m_ovf = 1'b0;
    chk("drain_valid_low", res_valid, 0);
    @(negedge clk);
    chk("drain_acc1", acc, 3);
    chk("drain_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("drain_acc2", acc, 5);
    @(negedge clk);
    chk("drain_acc3", acc, 8);
    @(negedge clk);
    chk("drain_acc4", acc, 12);
    get_result(13, 1'b0, 0);

    // Back-to-back pushes into an idle sequencer
    cmd_valid = 1'b1; cmd_ctrl = CTRL_PASS_B; cmd_cin_n = 1'b1; cmd_b = 4'd1; cmd_last = 1'b0;
    @(negedge clk);
    cmd_ctrl = CTRL_ADD; cmd_b = 4'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("b2b_acc1", acc, 1);
    @(negedge clk);
    chk("b2b_acc2", acc, 2);
    chk("b2b_busy", busy, 0);

    // Reset while executing with three entries queued
    push(CTRL_PASS_B, 1'b1, 4'd5, 1'b1);
    wait_valid();
    for (int i = 0; i < 4; i++) push(CTRL_ADD, 1'b1, 4'd1, 1'b0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_acc", acc, 6);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_acc", acc, 0);
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_acc", acc, 0);
    chk("post_rst_busy", busy, 0);
    m_acc = 0;
    m_ovf = 1'b0;

    // Random command sequences against the model
    for (int it = 0; it < 25; it++) begin
      clr_on_ovf = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        sel = $urandom_range(0, 3);
        c = (sel < 2) ? CTRL_ADD : ((sel == 2) ? CTRL_PASS_B : CTRL_ZERO);
        send(c, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), k == n - 1);
      end
      get_result(m_acc, m_ovf, $urandom_range(0, 2));
    end
    chk("final_acc", acc, m_acc);
    chk("final_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/acc_seq.md
ACC_SEQ -- requirements
Module: acc_seq

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, power of two >= 2: command queue depth.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  command queue can accept.
REQ-006 cmd_ctrl  input  5  ALU control {m, s[3:0]}.
REQ-007 cmd_cin_n  input  1  ALU carry-in, active-low.
REQ-008 cmd_b  input  4  ALU B operand.
REQ-009 cmd_last  input  1  after this command, present the result.
REQ-010 clr_on_ovf  input  1  quasi-static config: 1 = clear accumulator on add overflow.
REQ-011 res_valid  output  1  result available.
REQ-012 res_ready  input  1  result consumer accepts.
REQ-013 res_data  output  4  accumulator value at result time.
REQ-014 res_ovf  output  1  overflow occurred since the previous result handshake.
REQ-015 acc  output  4  current accumulator register.
REQ-016 busy  output  1  high when the queue is non-empty or the FSM is not IDLE.

Function
REQ-017 A command SHALL be pushed on a rising edge with cmd_valid && cmd_ready; cmd_ready = !full, so no push occurs while full, even if a pop happens in the same cycle.
REQ-018 The FSM SHALL have states IDLE (queue empty), EXEC, and RESULT.
REQ-019 In EXEC with a non-empty queue, one head command SHALL be popped and executed per cycle: acc <= ALU(a=acc, b, ctrl, cin_n).
REQ-020 Latency: a command pushed into an empty queue at edge N SHALL update acc at edge N+1.
REQ-021 Overflow event = ctrl == 5'b01001 (add) && ALU carry-out asserted (cout_n == 0); carry-out of any other op SHALL be ignored.
REQ-022 On an overflow event, acc SHALL load 0 if clr_on_ovf = 1, otherwise the 4-bit ALU result; a sticky ovf flag SHALL set in either case.
REQ-023 On executing a command with cmd_last = 1, the FSM SHALL enter RESULT at the same edge.
REQ-024 In RESULT, res_valid = 1, res_data = acc, and res_ovf = sticky flag; the queue SHALL still accept pushes but SHALL NOT pop.
REQ-025 res_valid, res_data and res_ovf SHALL hold stable until res_valid && res_ready.
REQ-026 On the result handshake, the sticky flag SHALL clear and the FSM SHALL go to EXEC if the queue is non-empty, else to IDLE.
REQ-027 An overflow in the last command SHALL be reflected in res_ovf of that same result.
REQ-028 IDLE SHALL go to EXEC when the queue becomes non-empty; EXEC SHALL go to IDLE when it pops a non-last final entry, leaving the queue empty.
REQ-029 Queue pointers SHALL wrap modulo FIFO_DEPTH; a simultaneous push and pop on a non-full, non-empty queue SHALL keep the count unchanged.
REQ-030 res_valid SHALL be 0 in IDLE and EXEC.

Reset
REQ-031 With rst_n low, the block SHALL set acc = 0, queue empty, sticky flag = 0, FSM = IDLE, res_valid = 0, res_data = 0, res_ovf = 0, busy = 0, and cmd_ready = 1.
REQ-032 Reset mid-operation SHALL discard all queued commands and any pending result without emitting a handshake.

Structure
REQ-033 A shared constants file SHALL hold the ctrl encodings: ADD = 5'b01001, PASS_B = 5'b11010, ZERO = 5'b10011, and the FSM state codes.
REQ-034 The existing alu_4bit SHALL be instantiated once (a = acc, b, s, m, cin_re, cout_re, y), and the command queue SHALL be inline in this module.

Verification
REQ-035 PASS_B b=3, then ADD cin_n=1 b=5 last -> res_data=8, res_ovf=0, busy=0 after handshake.
REQ-036 clr_on_ovf=1: PASS_B 12, ADD 7 last -> res_data=0, res_ovf=1; repeat with clr_on_ovf=0 -> res_data=3, res_ovf=1.
REQ-037 Hold res_ready=0, push 5 commands with FIFO_DEPTH=4 while in RESULT -> cmd_ready=0 after 4 pushes; release res_ready -> queued ops execute one per cycle, in order.
REQ-038 Back-to-back pushes of PASS_B 1 and ADD 1 on consecutive cycles, with the queue never full -> acc shows 1 then 2 on consecutive edges.
REQ-039 Assert rst_n=0 during EXEC with 3 queued commands -> acc=0, res_valid=0, busy=0 immediately; no execution after release until a new push.
